// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for an N-digit common-cathode
// seven-segment display. It drives one shared registered decoder (one cycle of
// latency) and generates one-hot digit enables that line up with the decoder's
// segment outputs.
// Optional build macro: SEG_SCAN_DIM_EN adds the brightness[2:0] input, which
// shortens the lit part of every dwell without changing the frame timing.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic                    lz_blank,
`ifdef SEG_SCAN_DIM_EN
  input  logic [2:0]              brightness,
`endif
  output logic [3:0]              dec_value,
  output logic                    dec_blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  localparam int unsigned CMAX = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    GUARD,
    DRIVE
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    guard_last;
  logic                    drive_last;

  logic [4*NUM_DIGITS-1:0] shadow_val;
  logic [NUM_DIGITS-1:0]   shadow_blank;

  logic [NUM_DIGITS-1:0]   lz_vec;
  logic                    higher_dark;
  logic [3:0]              nib;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    dwell_on;
  logic [NUM_DIGITS-1:0]   en_d;

  // Shadow copy of the digit values; dark until the first load.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_val   <= '0;
      shadow_blank <= '1;
    end else if (load) begin
      shadow_val   <= value_in;
      shadow_blank <= blank_in;
    end
  end

  // Leading-zero mask: walk down from the top digit while everything above is dark.
  always_comb begin
    lz_vec      = '0;
    higher_dark = 1'b1;
    nib         = '0;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      nib         = shadow_val[4*i +: 4];
      lz_vec[i]   = lz_blank && (nib == 4'd0) && higher_dark;
      higher_dark = higher_dark && ((nib == 4'd0) || shadow_blank[i]);
    end
  end

  // Decoder inputs for the digit currently indexed.
  always_comb begin
    cur_nib   = shadow_val[{idx_q, 2'b00} +: 4];
    cur_blank = shadow_blank[idx_q] | lz_vec[idx_q];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= GUARD;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state: dwell/guard counting and digit index advance.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    idx_d      = idx_q;
    guard_last = 1'b0;
    drive_last = 1'b0;
    case (state_q)
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          guard_last = 1'b1;
          state_d    = DRIVE;
          cnt_d      = '0;
        end
      end
      DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          drive_last = 1'b1;
          state_d    = GUARD;
          cnt_d      = '0;
          idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
      end
      default: begin
        state_d = GUARD;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef SEG_SCAN_DIM_EN
  logic [2:0]  bright_q;
  logic [31:0] dim_limit;

  // Brightness is captured at DRIVE entry so a change never chops a dwell.
  always_ff @(posedge clk) begin
    if (reset) begin
      bright_q <= '1;
    end else if (guard_last) begin
      bright_q <= brightness;
    end
  end

  // Lit portion of the dwell, compared against the dwell count.
  always_comb begin
    dim_limit = ((32'(bright_q) + 32'd1) * 32'(SCAN_DIV)) >> 3;
    dwell_on  = (32'(cnt_q) < dim_limit);
  end
`else
  assign dwell_on = 1'b1;
`endif

  // Enable for the digit being driven; registered below so it trails the
  // decoder inputs by the decoder's one-cycle latency.
  always_comb begin
    en_d = '0;
    if ((state_q == DRIVE) && dwell_on) begin
      en_d[idx_q] = 1'b1;
    end
  end

  // Registered outputs: decoder inputs latched at DRIVE entry, blanked in GUARD.
  always_ff @(posedge clk) begin
    if (reset) begin
      dec_value  <= '0;
      dec_blank  <= 1'b1;
      digit_en   <= '0;
      frame_done <= 1'b0;
    end else begin
      if (guard_last) begin
        dec_value <= cur_nib;
        dec_blank <= cur_blank;
      end else if (drive_last) begin
        dec_blank <= 1'b1;
      end
      digit_en   <= en_d;
      frame_done <= drive_last && (idx_q == IDX_LAST);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYCLES=2).
// Expected digit displays are queued when stimulus is applied and checked by a
// monitor on every digit-enable rising edge.
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int S = 8;
  localparam int G = 2;
  localparam int FRAME = N * (S + G);
`ifdef SEG_SCAN_DIM_EN
  localparam int ON_LEN = 4;
`else
  localparam int ON_LEN = 8;
`endif
  localparam int GAP_LEN = S - ON_LEN + G;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   value_in;
  logic [3:0]    blank_in;
  logic          load;
  logic          lz_blank;
`ifdef SEG_SCAN_DIM_EN
  logic [2:0]    brightness;
`endif
  logic [3:0]    dec_value;
  logic          dec_blank;
  logic [3:0]    digit_en;
  logic          frame_done;

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .SCAN_DIV     (S),
    .GUARD_CYCLES (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value_in   (value_in),
    .blank_in   (blank_in),
    .load       (load),
    .lz_blank   (lz_blank),
`ifdef SEG_SCAN_DIM_EN
    .brightness (brightness),
`endif
    .dec_value  (dec_value),
    .dec_blank  (dec_blank),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         digit;
    logic [3:0] val;
    logic       blank;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;

  logic [15:0] m_val;
  logic [3:0]  m_blk;
  logic        m_lz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_blank(input int i);
    if (m_blk[i]) return 1'b1;
    if (!m_lz || i == 0) return 1'b0;
    if (m_val[4*i +: 4] != 4'd0) return 1'b0;
    for (int j = i + 1; j < N; j++) begin
      if (m_val[4*j +: 4] != 4'd0 && !m_blk[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic push_digit(input int i);
    exp_t e;
    e.digit = i;
    e.val   = m_val[4*i +: 4];
    e.blank = exp_blank(i);
    sb.push_back(e);
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) push_digit(i);
  endtask

  task automatic wait_frame(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 200);
    chk("frame_seen", 32'(frame_done), 1);
  endtask

  task automatic wait_rise(input int b);
    int n;
    n = 0;
    while (digit_en[b] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("en_rise_seen", 32'(digit_en[b]), 1);
  endtask

  // Called at a frame_done sample: the load lands on digit 0's DRIVE entry edge,
  // so digit 0 still shows the previous shadow and digits 1..3 the new one.
  task automatic do_step(input logic [15:0] v, input logic [3:0] b, input logic lz);
    int n;
    push_digit(0);
    @(posedge clk); #1;
    value_in = v; blank_in = b; lz_blank = lz; load = 1'b1;
    m_val = v; m_blk = b; m_lz = lz;
    for (int i = 1; i < N; i++) push_digit(i);
    @(posedge clk); #1;
    load = 1'b0;
    wait_frame(n);
    push_frame();
    wait_frame(n);
  endtask

  // Monitor: one-hot, enable length, dark gap, frame period, scoreboard on rise.
  initial begin
    logic [3:0] en_prev    = '0;
    logic [3:0] prev_val   = '0;
    logic       prev_blank = 1'b1;
    int         on_cnt     = 0;
    int         off_cnt    = 0;
    int         fd_cnt     = 0;
    bit         have_fall  = 0;
    bit         aborted    = 1;
    bit         fd_have    = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      chk("onehot0", 32'($onehot0(digit_en)), 1);
      if (reset) begin
        aborted   = 1;
        have_fall = 0;
        fd_have   = 0;
      end
      if (digit_en != 4'd0) begin
        if (en_prev == 4'd0) begin
          if (have_fall && !aborted) chk("dark_gap", 32'(off_cnt), 32'(GAP_LEN));
          aborted = 0;
          on_cnt  = 0;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("en_digit", 32'(digit_en), 32'(1) << e.digit);
            chk("lead_value", 32'(prev_val), 32'(e.val));
            chk("lead_blank", 32'(prev_blank), 32'(e.blank));
            chk("dec_value", 32'(dec_value), 32'(e.val));
            chk("dec_blank", 32'(dec_blank), 32'(e.blank));
          end
        end
        on_cnt++;
      end else begin
        if (en_prev != 4'd0) begin
          if (!aborted) begin
            chk("en_length", 32'(on_cnt), 32'(ON_LEN));
            have_fall = 1;
          end
          off_cnt = 0;
        end
        off_cnt++;
      end
      fd_cnt++;
      if (frame_done === 1'b1 && !reset) begin
        if (fd_have) chk("frame_period", 32'(fd_cnt), 32'(FRAME));
        fd_have = 1;
        fd_cnt  = 0;
      end
      en_prev    = digit_en;
      prev_val   = dec_value;
      prev_blank = dec_blank;
    end
  end

  // Directed sequence.
  initial begin
    int n;
    logic [15:0] cv [5] = '{16'h0070, 16'h0070, 16'h0050, 16'h1005, 16'h0000};
    logic [3:0]  cb [5] = '{4'b0000,  4'b0000,  4'b1000,  4'b0000,  4'b0000};
    logic        cl [5] = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b1};

    reset = 1'b1; load = 1'b0; value_in = '0; blank_in = '0; lz_blank = 1'b0;
`ifdef SEG_SCAN_DIM_EN
    brightness = 3'd3;
`endif

    // Reset: dark, no enables, no frame pulse.
    repeat (3) begin
      @(negedge clk);
      chk("rst_digit_en", 32'(digit_en), 0);
      chk("rst_dec_blank", 32'(dec_blank), 1);
      chk("rst_dec_value", 32'(dec_value), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m_val = '0; m_blk = '1; m_lz = 1'b0;

    // Unloaded shadow scans dark digits; first frame ends FRAME edges after reset.
    push_frame();
    wait_frame(n);
    chk("first_frame_len", 32'(n), 32'(FRAME + 1));
    push_frame();
    wait_frame(n);

    // Basic scan.
    do_step(16'h1234, 4'b0000, 1'b0);

    // Leading-zero suppression cases.
    for (int k = 0; k < 5; k++) do_step(cv[k], cb[k], cl[k]);

    // Back to a plain pattern before the mid-dwell load.
    do_step(16'h1234, 4'b0000, 1'b0);

    // Load during digit 1's 4th DRIVE cycle: digit 1 keeps the old nibble.
    push_digit(0);
    push_digit(1);
    wait_rise(1);
    @(posedge clk);
    @(posedge clk); #1;
    value_in = 16'hABCD; blank_in = 4'b0000; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    m_val = 16'hABCD; m_blk = 4'b0000;
    push_digit(2);
    push_digit(3);
    wait_frame(n);
    push_frame();
    wait_frame(n);

    // One-cycle reset in the middle of digit 2's DRIVE.
    push_digit(0);
    push_digit(1);
    push_digit(2);
    wait_rise(2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_val = '0; m_blk = '1;
    push_digit(0);
    @(negedge clk);
    chk("midrst_digit_en", 32'(digit_en), 0);
    chk("midrst_dec_blank", 32'(dec_blank), 1);
    chk("midrst_dec_value", 32'(dec_value), 0);
    n = 1;
    while (digit_en == 4'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("restart_latency", 32'(n), 4);
    chk("restart_digit", 32'(digit_en), 1);
    push_digit(1);
    push_digit(2);
    push_digit(3);
    wait_frame(n);
    push_frame();
    wait_frame(n);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an N-digit common-cathode seven-segment display. It shares one registered sevensegment decoder instance across all digits.
- Holds a shadow copy of the digit values.
- Steps through the digits with a programmable dwell time and inserts a guard interval between digits to suppress ghosting.
- Drives the one-hot digit enables, aligned to the decoder's one-cycle output latency.
- Sits between the register/status logic and the display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned; legal 2..8
SCAN_DIV, 1000, clk cycles each digit is driven (DRIVE dwell); legal >= 2
GUARD_CYCLES, 4, clk cycles all digits are dark between digits; legal >= 1

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high reset
value_in  input  4*NUM_DIGITS  digit nibbles; digit i = value_in[4i+3:4i]; digit 0 = least significant
blank_in  input  NUM_DIGITS  per-digit forced blank, 1 = dark
load  input  1  1-cycle strobe; captures value_in/blank_in into the shadow registers
lz_blank  input  1  1 = leading-zero suppression enabled
dec_value  output  4  nibble to the decoder's value input
dec_blank  output  1  to the decoder's blank input
digit_en  output  NUM_DIGITS  one-hot digit common enable, aligned to decoder segments
frame_done  output  1  1-cycle pulse at end of the last digit's DRIVE

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. The reset is sampled only on posedge clk.
- Reset state:
  - shadow values = 0; shadow blanks = all 1s (display dark until the first load).
  - state = GUARD, digit index = 0, dwell counter = 0.
  - dec_value = 0, dec_blank = 1, digit_en = 0, frame_done = 0.
- Shadow load: when load = 1, the shadow registers take value_in/blank_in on that edge. Shadow contents are sampled only at DRIVE entry, so a load mid-dwell takes effect at the next digit. If load coincides with DRIVE entry, the old shadow is used for that digit.
- State machine (registered, two states):
  - GUARD: counter runs 0..GUARD_CYCLES-1. dec_blank = 1, dec_value holds its last value. On the last count, go to DRIVE and clear the counter.
  - DRIVE: counter runs 0..SCAN_DIV-1. On the entry edge, register:
    - dec_value = shadow nibble of the current index;
    - dec_blank = shadow blank of the index OR the leading-zero condition.
    Both are held for the whole dwell. On the last count:
    - go to GUARD;
    - index = index + 1, wrapping from NUM_DIGITS-1 to 0;
    - if the index was NUM_DIGITS-1, pulse frame_done for exactly one cycle, coincident with the first GUARD cycle.
- Digit enable alignment: the decoder adds 1 cycle of latency. digit_en[i] = 1 for exactly SCAN_DIV consecutive cycles, starting 1 cycle after dec_value/dec_blank for digit i first appear. At most one bit is ever set. digit_en is 0 throughout reset and during at least GUARD_CYCLES-1 cycles between consecutive digits.
- Leading-zero condition for digit i (i >= 1): lz_blank = 1 AND shadow nibble i = 0 AND every higher digit j > i is (nibble = 0 OR forced blank). Digit 0 is never leading-zero blanked.
- Frame period = NUM_DIGITS*(SCAN_DIV+GUARD_CYCLES) cycles.
- Reset mid-dwell: outputs take reset values on the next edge; the scan restarts at digit 0 GUARD.
- No handshake back-pressure. The load input is always accepted.

Optional Feature:
Macro SEG_SCAN_DIM_EN.
- Defined: adds input port brightness[2:0]. Within DRIVE, digit_en is forced to 0 once the aligned dwell count >= ((brightness+1)*SCAN_DIV)>>3. brightness = 7 gives the full dwell. The value is sampled at DRIVE entry. Frame timing and frame_done are unchanged.
- Undefined: the port is absent and every dwell is full (digit_en high for all SCAN_DIV cycles).

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYCLES=2):
1. Reset for 3 cycles with no load -> digit_en = 0 and dec_blank = 1 every cycle. frame_done pulses every 40 cycles.
2. load with value_in = 16'h1234, blank_in = 0 -> dec_value sequence 4,3,2,1 repeating. Each digit_en bit is high for 8 cycles, 1 cycle after the matching dec_value, with a 2-cycle dark gap. No two enable bits are ever high together.
3. value_in = 16'h0070, lz_blank = 1 -> digits 3 and 2 blank (dec_blank = 1); digit 1 shows 7; digit 0 shows 0. With lz_blank = 0, all four digits show.
4. load of 16'hABCD issued in the 4th DRIVE cycle of digit 1 -> digit 1 still shows the old nibble; digit 2 shows B.
5. reset asserted for 1 cycle mid-DRIVE of digit 2 -> next cycle digit_en = 0 and dec_blank = 1. The scan restarts at digit 0 after 2 GUARD cycles. Shadow returns to all-blank.
6. SEG_SCAN_DIM_EN with brightness = 3 -> each digit_en bit is high for exactly 4 cycles per dwell. The frame period stays 40 cycles.
